// File: rtl/fetch_stage_pkg.sv
// Shared encodings for the instruction fetch stage: NOP, region nibbles,
// fetch-source selects and the PC region decoder.
package fetch_stage_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [3:0]  BIOS_NIB  = 4'h4;
    localparam logic [3:0]  IMEM_NIB  = 4'h1;

    typedef enum logic [1:0] {
        SRC_NONE = 2'b00,
        SRC_BIOS = 2'b01,
        SRC_IMEM = 2'b10
    } fetch_src_e;

    function automatic fetch_src_e region_of(input logic [31:0] pc);
        fetch_src_e src;
        src = SRC_NONE;
        if (pc[31:28] == BIOS_NIB)
            src = SRC_BIOS;
        else if (pc[31:28] == IMEM_NIB)
            src = SRC_IMEM;
        return src;
    endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry hold register for the fetch output. Flush and release both empty
// it and take priority over capture.
module fetch_hold_buf
    import fetch_stage_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             capture_i,
    input  logic             release_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (flush_i || release_i) begin
            valid_d = 1'b0;
        end else if (capture_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= WIDTH'(NOP_INSTR);
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, drives BIOS/IMEM sync-read ports, and
// presents one instruction per cycle with stall hold and zero-penalty redirect.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h4000_0000,
    parameter int          BIOS_AWIDTH = 12,
    parameter int          IMEM_AWIDTH = 14
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   redirect_valid,
    input  logic [31:0]            redirect_pc,
    output logic [BIOS_AWIDTH-1:0] bios_addr,
    input  logic [31:0]            bios_dout,
    output logic [IMEM_AWIDTH-1:0] imem_addr,
    input  logic [31:0]            imem_dout,
    output logic [31:0]            instr,
    output logic [31:0]            instr_pc,
    output logic                   instr_valid,
    output logic                   fetch_fault
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic        out_valid_q, out_valid_d;
    fetch_src_e  out_src_q, out_src_d;

    logic [31:0] req_pc;
    logic [31:0] mem_instr;
    logic [31:0] hold_data;
    logic        hold_v;
    logic        advance;

    assign req_pc    = redirect_valid ? redirect_pc : pc_q;
    assign bios_addr = req_pc[BIOS_AWIDTH+1:2];
    assign imem_addr = req_pc[IMEM_AWIDTH+1:2];

    // A redirect always moves the pipe, even under stall.
    assign advance = redirect_valid || !stall;

    always_comb begin
        mem_instr = NOP_INSTR;
        if (out_valid_q) begin
            case (out_src_q)
                SRC_BIOS: mem_instr = bios_dout;
                SRC_IMEM: mem_instr = imem_dout;
                default:  mem_instr = NOP_INSTR;
            endcase
        end
    end

    // Memory output moves on after the first stalled cycle, so grab it then.
    fetch_hold_buf #(.WIDTH(32)) u_hold (
        .clk       (clk),
        .rst       (rst),
        .capture_i (stall && !redirect_valid && out_valid_q && !hold_v),
        .release_i (!stall && hold_v),
        .flush_i   (redirect_valid),
        .data_i    (mem_instr),
        .data_o    (hold_data),
        .valid_o   (hold_v)
    );

    always_comb begin
        pc_d        = pc_q;
        out_pc_d    = out_pc_q;
        out_valid_d = out_valid_q;
        out_src_d   = out_src_q;
        if (advance) begin
            pc_d        = req_pc + 32'd4;
            out_pc_d    = req_pc;
            out_valid_d = 1'b1;
            out_src_d   = region_of(req_pc);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            out_pc_q    <= RESET_PC;
            out_valid_q <= 1'b0;
            out_src_q   <= SRC_NONE;
        end else begin
            pc_q        <= pc_d;
            out_pc_q    <= out_pc_d;
            out_valid_q <= out_valid_d;
            out_src_q   <= out_src_d;
        end
    end

    assign instr       = hold_v ? hold_data : mem_instr;
    assign instr_pc    = out_pc_q;
    assign instr_valid = out_valid_q;
    assign fetch_fault = out_valid_q && (out_src_q == SRC_NONE);

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios with literal
// expectations, then randomized stall/redirect/reset against a PC-level model.
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h4000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [11:0] bios_addr;
    logic [13:0] imem_addr;
    logic [31:0] bios_dout = 32'h0;
    logic [31:0] imem_dout = 32'h0;
    logic [31:0] instr, instr_pc;
    logic        instr_valid, fetch_fault;

    int checks = 0;
    int failures = 0;

    // Model: what is on the output (pc, valid) and the next sequential PC.
    logic [31:0] m_pc, m_next;
    logic        m_valid;
    logic        m_known = 1'b0;

    fetch_stage #(
        .RESET_PC(RST_PC), .BIOS_AWIDTH(12), .IMEM_AWIDTH(14)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .bios_addr(bios_addr), .bios_dout(bios_dout),
        .imem_addr(imem_addr), .imem_dout(imem_dout),
        .instr(instr), .instr_pc(instr_pc),
        .instr_valid(instr_valid), .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] bios_fn(input logic [11:0] k);
        return 32'h0000_0100 + 32'(k);
    endfunction

    function automatic logic [31:0] imem_fn(input logic [13:0] k);
        return 32'h8000_0000 | (32'(k) * 32'd3);
    endfunction

    function automatic logic [31:0] memval(input logic [31:0] pc);
        if (pc[31:28] == 4'h4) return bios_fn(pc[13:2]);
        if (pc[31:28] == 4'h1) return imem_fn(pc[15:2]);
        return NOP;
    endfunction

    // Synchronous-read memories, one cycle latency.
    always @(posedge clk) begin
        bios_dout <= bios_fn(bios_addr);
        imem_dout <= imem_fn(imem_addr);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Apply inputs for the coming edge and check the combinational addresses.
    task automatic drive(input logic r, input logic s, input logic rv, input logic [31:0] rp);
        logic [31:0] req;
        rst = r; stall = s; redirect_valid = rv; redirect_pc = rp;
        #1;
        if (m_known) begin
            req = rv ? rp : m_next;
            check("bios_addr", 32'(bios_addr), 32'(req[13:2]));
            check("imem_addr", 32'(imem_addr), 32'(req[15:2]));
        end
    endtask

    // Clock edge, model update, then compare all outputs on the falling edge.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_valid = 1'b0; m_pc = RST_PC; m_next = RST_PC; m_known = 1'b1;
        end else if (redirect_valid) begin
            m_valid = 1'b1; m_pc = redirect_pc; m_next = redirect_pc + 32'd4;
        end else if (!stall) begin
            m_valid = 1'b1; m_pc = m_next; m_next = m_next + 32'd4;
        end
        @(negedge clk);
        check("instr_valid", 32'(instr_valid), 32'(m_valid));
        check("instr_pc", instr_pc, m_pc);
        check("instr", instr, m_valid ? memval(m_pc) : NOP);
        check("fetch_fault", 32'(fetch_fault),
              32'(m_valid && m_pc[31:28] != 4'h4 && m_pc[31:28] != 4'h1));
    endtask

    initial begin
        logic [31:0] rp;
        logic r, s, rv;

        // Reset for three cycles
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 0); tick();
            check("rst_valid", 32'(instr_valid), 32'h0);
            check("rst_instr", instr, 32'h0000_0013);
        end
        rst = 1'b0; #1;
        check("first_bios_addr", 32'(bios_addr), 32'h0);

        drive(0, 0, 0, 0); tick();
        check("first_instr", instr, 32'h0000_0100);
        check("first_pc", instr_pc, 32'h4000_0000);
        check("first_valid", 32'(instr_valid), 32'h1);

        for (int k = 1; k <= 2; k++) begin
            drive(0, 0, 0, 0); tick();
        end
        // Stall for three cycles while 0x4000_0008 is on the output
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 0); tick();
            check("stall_pc", instr_pc, 32'h4000_0008);
            check("stall_instr", instr, 32'h0000_0102);
        end
        drive(0, 0, 0, 0); tick();
        check("release_pc", instr_pc, 32'h4000_000C);
        check("release_instr", instr, 32'h0000_0103);

        // Streaming: no bubbles
        for (int k = 4; k < 12; k++) begin
            drive(0, 0, 0, 0); tick();
            check("stream_pc", instr_pc, 32'h4000_0000 + 32'(4 * k));
            check("stream_instr", instr, 32'h0000_0100 + 32'(k));
        end

        // Redirect into IMEM
        drive(0, 0, 1, 32'h1000_0040);
        check("redir_imem_addr", 32'(imem_addr), 32'h10);
        tick();
        check("redir_instr", instr, 32'h8000_0030);
        check("redir_pc", instr_pc, 32'h1000_0040);
        drive(0, 0, 0, 0); tick();
        check("redir_next_pc", instr_pc, 32'h1000_0044);
        check("redir_next_instr", instr, 32'h8000_0033);

        // Redirect during stall with hold buffer loaded
        drive(0, 1, 0, 0); tick();
        drive(0, 1, 0, 0); tick();
        drive(0, 1, 1, 32'h4000_0020); tick();
        check("rs_instr", instr, 32'h0000_0108);
        check("rs_pc", instr_pc, 32'h4000_0020);
        drive(0, 0, 0, 0); tick();
        check("rs_next_instr", instr, 32'h0000_0109);

        // Unmapped region
        drive(0, 0, 1, 32'h2000_0000); tick();
        check("unmap_instr", instr, 32'h0000_0013);
        check("unmap_fault", 32'(fetch_fault), 32'h1);
        check("unmap_valid", 32'(instr_valid), 32'h1);
        drive(0, 0, 0, 0); tick();

        // Wrap across 2^32
        drive(0, 0, 1, 32'hFFFF_FFFC); tick();
        drive(0, 0, 0, 0); tick();
        check("wrap_pc", instr_pc, 32'h0000_0000);

        // Reset while stalled
        drive(0, 0, 1, 32'h4000_0100); tick();
        drive(0, 1, 0, 0); tick();
        drive(1, 1, 0, 0); tick();
        check("rst_stall_valid", 32'(instr_valid), 32'h0);
        check("rst_stall_instr", instr, 32'h0000_0013);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom % 64) == 0;
            s  = ($urandom % 4) == 0;
            rv = ($urandom % 8) == 0;
            case ($urandom % 5)
                0, 1: rp = {4'h4, 20'h0, 6'($urandom), 2'b00};
                2:    rp = {4'h1, 14'h0, 12'($urandom), 2'b00};
                3:    rp = {4'($urandom), 26'($urandom), 2'b00};
                default: rp = 32'hFFFF_FFF0 + 32'(4 * ($urandom % 4));
            endcase
            drive(r, s, rv, rp);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage, directly upstream of the control decoder: owns the PC and drives the BIOS and IMEM synchronous-read ports.
- Presents one aligned 32-bit instruction per cycle, with its PC and a valid flag, to the decode stage.
- Honours a decode-side stall with a one-entry hold buffer, and honours a zero-penalty redirect from branch/jump resolution.
- Substitutes a NOP whenever no valid instruction is available, so the decoder always sees a defined opcode.

Parameters:
- RESET_PC, 32'h4000_0000, PC loaded on reset (BIOS base).
- BIOS_AWIDTH, 12, BIOS word-address width.
- IMEM_AWIDTH, 14, IMEM word-address width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  decode cannot accept the current instruction; hold it.
- redirect_valid  in  1  taken branch/jump resolved downstream.
- redirect_pc  in  32  redirect target.
- bios_addr  out  BIOS_AWIDTH  BIOS word address (combinational).
- bios_dout  in  32  BIOS read data, 1-cycle latency.
- imem_addr  out  IMEM_AWIDTH  IMEM word address (combinational).
- imem_dout  in  32  IMEM read data, 1-cycle latency.
- instr  out  32  instruction to decoder.
- instr_pc  out  32  PC of instr.
- instr_valid  out  1  instr is a real fetched instruction.
- fetch_fault  out  1  instr_pc lies outside BIOS/IMEM.

Behaviour:
- State:
  - pc_q: next PC to request.
  - out_pc_q, out_valid_q, out_src_q: request issued last cycle (source is BIOS/IMEM/none).
  - hold_q, hold_v_q: stall buffer.
- Request address:
  - req_pc = redirect_valid ? redirect_pc : pc_q.
  - Low two bits are ignored; word address = req_pc[31:2] truncated to the port width.
  - Both address ports are driven from req_pc every cycle.
- Region decode:
  - req_pc[31:28]==4'h4 → BIOS.
  - req_pc[31:28]==4'h1 → IMEM.
  - Anything else → none.
- Reset (rst=1, sync): pc_q<=RESET_PC, out_valid_q<=0, hold_v_q<=0, out_pc_q<=RESET_PC. Outputs during and after the reset edge: instr_valid=0, instr=NOP, fetch_fault=0.
- First fetch: the first cycle with rst=0 requests RESET_PC. One cycle later instr=mem[RESET_PC], instr_valid=1.
- Latency: 1 cycle from address presentation to instr.
- Normal advance (no stall, no redirect): pc_q<=pc_q+4, out_pc_q<=pc_q, out_valid_q<=1. Sustained throughput is 1 instruction/cycle.
- Output mux:
  - instr = hold_v_q ? hold_q : (out_valid_q ? (src BIOS ? bios_dout : src IMEM ? imem_dout : NOP) : NOP).
  - NOP = 32'h0000_0013.
- Stall:
  - pc_q and out_pc_q hold.
  - First stall cycle with out_valid_q=1: capture the current mem instr into hold_q and set hold_v_q, because the memory output changes next cycle.
  - Later stall cycles leave hold_q untouched.
  - stall deassert: the held instr is consumed that cycle and hold_v_q<=0. The following cycle shows mem[pc_q], which was re-requested during the stall.
- Redirect (priority over stall):
  - Issued the same cycle: req_pc=redirect_pc, then pc_q<=redirect_pc+4, out_pc_q<=redirect_pc, out_valid_q<=1, hold_v_q<=0.
  - The wrong-path instruction on the output in the redirect cycle is dropped by downstream.
  - Next cycle: instr=mem[redirect_pc].
- Redirect plus stall in the same cycle: the redirect wins; the hold buffer is flushed.
- Unmapped PC: out_src_q=none, instr=NOP, instr_valid=1, fetch_fault=1 while that PC is on the output.
- Wrap: pc_q+4 wraps modulo 2^32 with no special handling.
- Reset mid-stall or mid-redirect: reset wins; all state is cleared as above.

Decomposition:
- Shared header (alongside opcode.vh): NOP encoding, region base nibbles (BIOS 4'h4, IMEM 4'h1), source-select encodings.
- Sub-module: fetch_hold_buf, the one-entry hold register with capture/release/flush controls, instantiated once.

Test Plan:
- Reset: hold rst 3 cycles, release → bios_addr=0 on the first cycle; next cycle instr=bios[0], instr_pc=32'h4000_0000, instr_valid=1, and instr_valid=0 during reset.
- Streaming: BIOS words k→32'h0000_0100+k, no stall, 8 cycles → instr_pc increments by 4 each cycle, instr matches, no bubbles.
- Stall: assert stall 3 cycles while instr_pc=32'h4000_0008 → instr/instr_pc stay constant all 3 cycles; after release the next instr_pc=32'h4000_000C, none skipped or duplicated.
- Redirect: redirect_valid=1, redirect_pc=32'h1000_0040 for one cycle → imem_addr=14'h010 that cycle; next cycle instr=imem[16], instr_pc=32'h1000_0040; then 32'h1000_0044.
- Redirect during stall: stall=1 and hold_v set, then redirect to 32'h4000_0020 with stall=1 → next cycle instr=bios[8], held instruction discarded.
- Unmapped: redirect to 32'h2000_0000 → next cycle instr=32'h0000_0013, fetch_fault=1, instr_valid=1.
